// File: rtl/fetch_queue.sv
// Instruction prefetch buffer: owns the fetch PC, fetches one ROM word per cycle and
// queues up to DEPTH {pc, instr} entries for decode; a taken branch flushes and redirects.
module fetch_queue #(
  parameter int               XLEN      = 32,
  parameter int               DEPTH     = 4,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [XLEN-1:0]  NOP_INSTR = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [XLEN-1:0]            rom_address,
  input  logic [XLEN-1:0]            rom_data,
  input  logic                       PCSrc,
  input  logic [XLEN-1:0]            branch_target,
  input  logic                       stall,
  output logic [XLEN-1:0]            instr,
  output logic [XLEN-1:0]            pc,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [XLEN-1:0] r_fpc;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_mem_pc    [DEPTH];
  logic [XLEN-1:0] r_mem_instr [DEPTH];

  logic            w_valid;
  logic            w_pop;
  logic            w_push;
  logic [XLEN-1:0] w_target;

  assign w_valid  = (r_count != '0);
  assign w_pop    = w_valid & ~stall;
  // A full queue still accepts a word when the head leaves in the same cycle.
  assign w_push   = (r_count < FULL_COUNT) | w_pop;
  assign w_target = branch_target & ~XLEN'(3);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fpc    <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (PCSrc) begin
      r_fpc    <= w_target;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fpc    <= r_fpc + XLEN'(4);
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the entry storage has no reset; an entry is only ever read while r_count
  // marks it occupied, so its power-up contents are never observed.
  always_ff @(posedge clk) begin
    if (!rst && !PCSrc && w_push) begin
      r_mem_pc[r_wr_ptr]    <= r_fpc;
      r_mem_instr[r_wr_ptr] <= rom_data;
    end
  end

  assign rom_address = r_fpc;
  assign valid       = w_valid;
  assign count       = r_count;
  assign instr       = w_valid ? r_mem_instr[r_rd_ptr] : NOP_INSTR;
  assign pc          = w_valid ? r_mem_pc[r_rd_ptr]    : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a queue-based scoreboard model checked every cycle,
// a table of hand-derived post-edge expectations, and a RESET_PC wrap-around run.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        pcsrc;
    logic [31:0] target;
    logic [31:0] e_count;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_addr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] rom_address, rom_data, instr, pc;
  logic        valid;
  logic [2:0]  count;

  logic        w_rst = 1'b1;
  logic [31:0] w_rom_address, w_rom_data, w_instr, w_pc;
  logic        w_valid;
  logic [2:0]  w_count;

  int n_tests = 0;
  int n_fail  = 0;

  ent_t        sb[$];
  logic [31:0] m_fpc = '0;
  bit          m_known = 1'b0;
  vec_t        vecs[23];

  always #5 clk = ~clk;

  // ROM[i] = i: the word at byte address a is a/4.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  assign rom_data   = rom(rom_address);
  assign w_rom_data = rom(w_rom_address);

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .NOP_INSTR(NOP)) u_dut (
    .clk(clk), .rst(rst), .rom_address(rom_address), .rom_data(rom_data),
    .PCSrc(PCSrc), .branch_target(branch_target), .stall(stall),
    .instr(instr), .pc(pc), .valid(valid), .count(count)
  );

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(WRAP_PC), .NOP_INSTR(NOP)) u_wrap (
    .clk(clk), .rst(w_rst), .rom_address(w_rom_address), .rom_data(w_rom_data),
    .PCSrc(1'b0), .branch_target(32'h0), .stall(1'b0),
    .instr(w_instr), .pc(w_pc), .valid(w_valid), .count(w_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t v(input logic r, input logic s, input logic p, input logic [31:0] t,
                             input logic [31:0] c, input logic vl, input logic [31:0] epc,
                             input logic [31:0] ea);
    vec_t x;
    x.rst = r; x.stall = s; x.pcsrc = p; x.target = t;
    x.e_count = c; x.e_valid = vl; x.e_pc = epc; x.e_addr = ea;
    return x;
  endfunction

  // One clock cycle: drive inputs, check the presented state against the scoreboard
  // mid-cycle, advance the model, then return 1 time unit after the rising edge.
  task automatic cycle(input logic r, input logic s, input logic p, input logic [31:0] t);
    ent_t e;
    rst = r; stall = s; PCSrc = p; branch_target = t;
    @(negedge clk);
    if (m_known) begin
      check("sb_valid", {31'b0, valid}, {31'b0, sb.size() != 0});
      check("sb_count", {29'b0, count}, sb.size());
      check("sb_rom_address", rom_address, m_fpc);
    end
    if (r) begin
      sb.delete();
      m_fpc   = 32'h0;
      m_known = 1'b1;
    end else if (p) begin
      sb.delete();
      m_fpc = t & ~32'h3;
    end else begin
      if (sb.size() != 0 && !s) begin
        e = sb.pop_front();
        check("sb_pc", pc, e.pc);
        check("sb_instr", instr, e.instr);
      end
      if (sb.size() < DEPTH) begin
        sb.push_back('{pc: m_fpc, instr: rom(m_fpc)});
        m_fpc = m_fpc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Free-run from reset.
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("rst_valid", {31'b0, valid}, 32'h0);
    check("rst_count", {29'b0, count}, 32'h0);
    check("rst_rom_address", rom_address, 32'h0);
    check("rst_instr", instr, NOP);
    check("rst_pc", pc, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      check("free_pc", pc, 32'(4 * (k - 1)));
      check("free_instr", instr, 32'(k - 1));
      check("free_valid", {31'b0, valid}, 32'h1);
      check("free_count", {29'b0, count}, 32'h1);
    end

    // Stall fill, single-cycle release, flush while full, reset+flush, unstalled flush.
    vecs[0] = v(1, 0, 0, 32'h0,   0, 0, 32'h0,   32'h0);
    for (int k = 1; k <= 8; k++)
      vecs[k] = v(0, 1, 0, 32'h0, (k < 4) ? k : 4, 1, 32'h0, 32'(4 * ((k < 4) ? k : 4)));
    vecs[9]  = v(0, 0, 0, 32'h0,   4, 1, 32'h4,   32'h14);
    vecs[10] = v(0, 1, 0, 32'h0,   4, 1, 32'h4,   32'h14);
    vecs[11] = v(0, 1, 1, 32'h103, 0, 0, 32'h0,   32'h100);
    vecs[12] = v(0, 1, 0, 32'h0,   1, 1, 32'h100, 32'h104);
    vecs[13] = v(0, 0, 0, 32'h0,   1, 1, 32'h104, 32'h108);
    vecs[14] = v(0, 0, 0, 32'h0,   1, 1, 32'h108, 32'h10C);
    vecs[15] = v(0, 1, 0, 32'h0,   2, 1, 32'h108, 32'h110);
    vecs[16] = v(0, 1, 0, 32'h0,   3, 1, 32'h108, 32'h114);
    vecs[17] = v(1, 1, 1, 32'h200, 0, 0, 32'h0,   32'h0);
    vecs[18] = v(0, 0, 0, 32'h0,   1, 1, 32'h0,   32'h4);
    vecs[19] = v(0, 0, 0, 32'h0,   1, 1, 32'h4,   32'h8);
    vecs[20] = v(0, 0, 1, 32'h40,  0, 0, 32'h0,   32'h40);
    vecs[21] = v(0, 0, 0, 32'h0,   1, 1, 32'h40,  32'h44);
    vecs[22] = v(0, 0, 0, 32'h0,   1, 1, 32'h44,  32'h48);

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].stall, vecs[i].pcsrc, vecs[i].target);
      check($sformatf("vec%0d_count", i), {29'b0, count}, vecs[i].e_count);
      check($sformatf("vec%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].e_valid});
      check($sformatf("vec%0d_pc", i), pc, vecs[i].e_pc);
      check($sformatf("vec%0d_rom_address", i), rom_address, vecs[i].e_addr);
      check($sformatf("vec%0d_instr", i), instr,
            vecs[i].e_valid ? {2'b00, vecs[i].e_pc[31:2]} : NOP);
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);

    // Fetch PC wrap across 2^32 and several buffer pointer wraps.
    w_rst = 1'b1;
    @(posedge clk);
    #1;
    check("wrap_rst_rom_address", w_rom_address, WRAP_PC);
    check("wrap_rst_valid", {31'b0, w_valid}, 32'h0);
    w_rst = 1'b0;
    for (int k = 1; k <= 3 * DEPTH + 4; k++) begin
      logic [31:0] epc;
      @(posedge clk);
      #1;
      epc = WRAP_PC + 32'(4 * (k - 1));
      check("wrap_pc", w_pc, epc);
      check("wrap_instr", w_instr, {2'b00, epc[31:2]});
      check("wrap_count", {29'b0, w_count}, 32'h1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction prefetch buffer that replaces the single-register fetch stage in front of decode. It owns the fetch PC, reads one instruction word per cycle from the combinational instruction ROM, and buffers up to `DEPTH` fetched words with their PCs. Decode drains the buffer under a stall signal, and a taken branch from the back end flushes all buffered words and redirects fetch. This lets fetch keep running while decode is stalled and gives a clean flush point for branch redirection.

## Interface
Parameters:
- `XLEN`, 32, width of PC and instruction words.
- `DEPTH`, 4, number of queue entries; a power of two, ≥ 2.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `NOP_INSTR`, 32'h0000_0013, value driven on `instr` when the queue is empty.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `rom_address`  out  XLEN  current fetch PC; equals the internal fetch PC register.
- `rom_data`  in  XLEN  combinational ROM word at `rom_address`, valid in the same cycle.
- `PCSrc`  in  1  taken branch/jump; flush and redirect.
- `branch_target`  in  XLEN  redirect address, sampled when `PCSrc`=1.
- `stall`  in  1  decode cannot accept this cycle.
- `instr`  out  XLEN  head entry instruction; `NOP_INSTR` when empty.
- `pc`  out  XLEN  head entry PC; 0 when empty.
- `valid`  out  1  queue non-empty; head is presented.
- `count`  out  $clog2(DEPTH+1)  number of occupied entries.

## Operation
- State:
  - fetch PC `fpc`.
  - Circular buffer of `DEPTH` {pc, instr} entries.
  - Read pointer `rd_ptr` and write pointer `wr_ptr`, each $clog2(DEPTH) bits.
  - Occupancy counter `count`.
- pop = `valid` & ~`stall`.
- push = (`count` < `DEPTH`) | pop, i.e. pushing into a full queue is allowed when a pop happens in the same cycle.
- Push: write {`fpc`, `rom_data`} at `wr_ptr`; `wr_ptr` += 1 (wraps mod `DEPTH`); `fpc` += 4 (wraps mod 2^XLEN).
- Pop: `rd_ptr` += 1 (wraps mod `DEPTH`).
- `count` next value: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full, no pop: no push; `fpc` holds; `rom_address` is stable.
- Flush (`PCSrc`=1) has priority over push and pop:
  - `rd_ptr`, `wr_ptr` and `count` are cleared.
  - `fpc` ← {`branch_target`[XLEN-1:2], 2'b00}.
  - `rom_data` in the flush cycle is discarded.
  - The current head is not consumed, whatever `stall` is.
- Outputs are combinational from the head entry and `count`; no extra register stage.
- Reset mid-operation behaves exactly like the post-reset state, whatever the contents.
- Output reset values:
  - `rom_address` = `RESET_PC`.
  - `valid` = 0, `count` = 0.
  - `instr` = `NOP_INSTR`, `pc` = 0.

## Timing
- Fetch-to-present latency is 1 cycle: a word pushed on edge N is visible on `instr`/`pc` after edge N if the queue was empty.
- After `rst` deasserts, the first edge pushes `RESET_PC`; `valid`=1 in the following cycle.
- With `stall`=0 continuously: one instruction per cycle; `count` stays at 1; `pc` advances by 4 each cycle.
- With `stall`=1 continuously from empty:
  - `count` reaches `DEPTH` after `DEPTH` edges.
  - `rom_address` then holds at start + 4·`DEPTH`.
- After a flush on edge N:
  - `valid`=0 during cycle N+1.
  - The target word is presented from cycle N+2.
  - Branch penalty is fixed at 2 cycles.
- `PCSrc` and `rst` in the same cycle: `rst` wins; `fpc` = `RESET_PC`.

## Test plan
- Reset, then free-run 6 cycles, ROM[i]=i: `pc` sequence 0,4,8,12,16; `instr` matches ROM; `valid` low only in the first cycle.
- Hold `stall`=1 for 8 cycles (`DEPTH`=4), then release: `count` saturates at 4; `rom_address`=16 while full; after release, PCs 0,4,8,12,16 appear in order with no gaps or duplicates.
- Full queue, release `stall` for exactly one cycle: simultaneous push/pop; `count` stays 4; `rom_address` advances by 4 once.
- `PCSrc`=1 with target 0x103 while full and stalled: next cycle `count`=0, `valid`=0, `rom_address`=0x100; the cycle after, `pc`=0x100.
- Assert `rst` while `count`=3 and `PCSrc`=1: next cycle all outputs at reset values; fetch restarts at `RESET_PC`.
- `RESET_PC`=32'hFFFF_FFF8, free-run: PCs FFFF_FFF8, FFFF_FFFC, 0, 4; pointer wrap runs over ≥ 3·`DEPTH` cycles with no data corruption.
